// File: rtl/tri_fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// tri_fifo_reader_pkg
// Shared definitions for the triangle FIFO reader and the writer that fills it:
//   - TRI_W / COMP_W / N_VTX / N_COMP : packed triangle geometry
//   - tri_t    : unpacked triangle, [vertex][component][bit]
//   - state_t  : reader control states
//   - pack_idx : bit offset of (vertex, component) inside the packed word
//   - pack_tri : writer-side packing of a tri_t into a TRI_W word
// -----------------------------------------------------------------------------
package tri_fifo_reader_pkg;

    localparam int COMP_W = 32;
    localparam int N_VTX  = 3;
    localparam int N_COMP = 4;
    localparam int TRI_W  = COMP_W * N_VTX * N_COMP;   // 384

    typedef logic [N_VTX-1:0][N_COMP-1:0][COMP_W-1:0] tri_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Components are interleaved: all vertices of component 0 first, then
    // component 1, and so on.
    function automatic int pack_idx(input int v, input int c);
        return COMP_W * (N_VTX * c + v);
    endfunction

    function automatic logic [TRI_W-1:0] pack_tri(input tri_t t);
        logic [TRI_W-1:0] w;
        w = '0;
        for (int v = 0; v < N_VTX; v++) begin
            for (int c = 0; c < N_COMP; c++) begin
                w[pack_idx(v, c) +: COMP_W] = t[v][c];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tri_fifo_reader_unpack.sv
// -----------------------------------------------------------------------------
// tri_unpack
// Purely combinational slice of a packed triangle word into vertices.
// Ports:
//   data_i : packed triangle, TRI_W bits
//   tri_o  : unpacked triangle, tri_o[v][c] = vertex v, component c
// -----------------------------------------------------------------------------
module tri_unpack
    import tri_fifo_reader_pkg::*;
(
    input  logic [TRI_W-1:0] data_i,
    output tri_t             tri_o
);

    always_comb begin
        tri_o = '0;
        for (int v = 0; v < N_VTX; v++) begin
            for (int c = 0; c < N_COMP; c++) begin
                tri_o[v][c] = data_i[pack_idx(v, c) +: COMP_W];
            end
        end
    end

endmodule

// File: rtl/tri_fifo_reader.sv
// -----------------------------------------------------------------------------
// tri_fifo_reader
// Pulls packed triangles from a ready/valid FIFO once per frame and hands them
// one at a time to the downstream projection/raster stage. An all-zero word
// marks the end of the object.
// Ports:
//   clk_in, rst_in         : clock, synchronous active-high reset
//   new_frame_in           : frame-start pulse
//   s_tvalid_in/s_tready_out/s_tdata_in : FIFO read side
//   coor_out_1..3, valid_out, ds_ready_in : triangle to downstream
//   obj_done_out           : one-cycle end-of-object pulse
//   tri_count_out          : saturating count of triangles issued this frame
//   overrun_out            : sticky, a frame started before the object ended
// -----------------------------------------------------------------------------
module tri_fifo_reader
    import tri_fifo_reader_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    new_frame_in,
    input  logic                    s_tvalid_in,
    output logic                    s_tready_out,
    input  logic [TRI_W-1:0]        s_tdata_in,
    output logic [N_COMP-1:0][COMP_W-1:0] coor_out_1,
    output logic [N_COMP-1:0][COMP_W-1:0] coor_out_2,
    output logic [N_COMP-1:0][COMP_W-1:0] coor_out_3,
    output logic                    valid_out,
    input  logic                    ds_ready_in,
    output logic                    obj_done_out,
    output logic [CNT_W-1:0]        tri_count_out,
    output logic                    overrun_out
);

    state_t           state_q, state_d;
    tri_t             coor_q, coor_d;
    tri_t             tri_unpacked;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             is_marker;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    tri_unpack u_unpack (
        .data_i (s_tdata_in),
        .tri_o  (tri_unpacked)
    );

    assign s_tready_out = (state_q == FETCH);
    assign accept       = s_tvalid_in && s_tready_out;
    assign is_marker    = (s_tdata_in == '0);

    always_comb begin
        state_d = state_q;
        coor_d  = coor_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE, DONE: begin
                if (new_frame_in) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                // A frame start here does not abort; it only flags the overrun.
                if (new_frame_in) ovr_d = 1'b1;
                if (accept) begin
                    if (is_marker) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        coor_d  = tri_unpacked;
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (new_frame_in) ovr_d = 1'b1;
                if (valid_q && ds_ready_in) begin
                    valid_d = 1'b0;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            coor_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            coor_q  <= coor_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign coor_out_1    = coor_q[0];
    assign coor_out_2    = coor_q[1];
    assign coor_out_3    = coor_q[2];
    assign valid_out     = valid_q;
    assign obj_done_out  = done_q;
    assign tri_count_out = cnt_q;
    assign overrun_out   = ovr_q;

endmodule
